sp_ram_bytewe: RTL and testbench

Parametrised single-port RAM with per-byte write enables, a selectable read-during-write mode, optional output register, and a hardware clear sequencer. It replaces the fixed-size scratch RAMs used throughout the design. It sits behind any single-master datapath that needs addressable storage with a known post-reset content and a `dout_vld` strobe instead of implied timing.

---
 rtl/sp_ram_bytewe_pkg.sv | 21 ++
 rtl/sp_ram_bytewe_array.sv | 43 ++++
 rtl/sp_ram_bytewe.sv | 118 +++++++++++
 tb/tb_sp_ram_bytewe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_bytewe_pkg.sv
// Shared types and size helpers for the byte-write-enable scratch RAM.
// Imported by both the storage array and the top-level wrapper.
package sp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int calc_nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sp_ram_bytewe_array.sv
// Single-port storage with byte-masked writes and a selectable read-during-write result.
// q is registered: it reflects the access of the previous enabled cycle.
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = RDW_READ_FIRST,
  localparam int NB      = calc_nb(DATA_W, BYTE_W),
  localparam int DEPTH   = calc_depth(ADDR_W)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [NB-1:0]     be,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] merged;

  assign old_w = mem[addr];

  // For a read, merged collapses to the stored word, so the RDW mux is harmless there.
  always_comb begin
    merged = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) merged[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= merged;
      q <= (RDW_MODE == RDW_WRITE_FIRST) ? merged : old_w;
    end
  end

endmodule

// File: rtl/sp_ram_bytewe.sv
// Byte-write-enable single-port RAM with a post-reset/on-demand clear sweep and a dout_vld strobe.
// Handshake: a request is taken in any cycle where req=1 and busy=0; its data returns with one dout_vld pulse.
module sp_ram_bytewe
  import sp_ram_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          BYTE_W   = 8,
  parameter int          ADDR_W   = 4,
  parameter int          OUT_REG  = 0,
  parameter int          RDW_MODE = RDW_READ_FIRST,
  parameter logic [DATA_W-1:0] CLR_VAL = '0,
  localparam int         NB       = calc_nb(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [NB-1:0]     be,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy
);

  state_e            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_wr;
  logic              accept;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] hold;
  logic              vld1;

  assign busy   = (state == ST_CLEAR);
  assign clr_wr = busy & ~rst;
  assign accept = req & ~busy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr) begin
            clr_addr <= '0;
          end else if (clr_addr == {ADDR_W{1'b1}}) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

  // The sweep owns the port while busy; user requests are dropped there.
  assign ram_en   = accept | clr_wr;
  assign ram_we   = busy ? 1'b1 : we;
  assign ram_addr = busy ? clr_addr : addr;
  assign ram_be   = busy ? {NB{1'b1}} : be;
  assign ram_din  = busy ? CLR_VAL : din;

  sp_ram_array #(
    .DATA_W   (DATA_W),
    .BYTE_W   (BYTE_W),
    .ADDR_W   (ADDR_W),
    .RDW_MODE (RDW_MODE)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .be   (ram_be),
    .din  (ram_din),
    .q    (ram_q)
  );

  // hold keeps the last returned word so dout is stable between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1 <= 1'b0;
      hold <= '0;
    end else begin
      vld1 <= accept;
      if (vld1) hold <= ram_q;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic vld2;
      always_ff @(posedge clk) begin
        if (rst) vld2 <= 1'b0;
        else     vld2 <= vld1;
      end
      assign dout     = hold;
      assign dout_vld = vld2;
    end else begin : g_out_comb
      assign dout     = vld1 ? ram_q : hold;
      assign dout_vld = vld1;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_bytewe.sv
// Bench for sp_ram_bytewe: two instances share stimulus (read-first/latency 1 and write-first/latency 2)
// and are checked every cycle against a word-array model plus a table of hand-derived vectors.
module tb_sp_ram_bytewe;
  localparam logic [31:0] CLR_V = 32'hA5A5A5A5;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, clr, req, we;
  logic [3:0]  addr, be;
  logic [31:0] din;
  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b;

  always #5 clk = ~clk;

  sp_ram_bytewe #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0), .CLR_VAL(CLR_V)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr), .be(be), .din(din),
    .dout(dout_a), .dout_vld(vld_a), .busy(busy_a));

  sp_ram_bytewe #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1), .CLR_VAL(CLR_V)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr), .be(be), .din(din),
    .dout(dout_b), .dout_vld(vld_b), .busy(busy_b));

  // reference model
  logic [31:0] m_mem [DEPTH];
  int          clear_left;
  int          cyc;
  logic [31:0] exp_qa[$], exp_qb[$];
  int          due_qa[$], due_qb[$];
  logic [31:0] last_a, last_b;

  int total = 0;
  int bad   = 0;

  logic        seen_a, seen_b;
  logic [31:0] val_a, val_b;
  logic        collect_b;
  int          sb_q[$];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] exp_rf;
    logic [31:0] exp_wf;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [31:0] old_w, new_w;
    logic        exp_v;
    if (rst) begin
      clear_left = DEPTH;
      exp_qa.delete(); exp_qb.delete(); due_qa.delete(); due_qb.delete();
      last_a = '0; last_b = '0;
    end else if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = CLR_V;
      clear_left--;
      if (clr) clear_left = DEPTH;
    end else begin
      if (req) begin
        old_w = m_mem[addr];
        new_w = old_w;
        if (we) for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = din[8*i +: 8];
        m_mem[addr] = new_w;
        exp_qa.push_back(old_w); due_qa.push_back(cyc + 1);
        exp_qb.push_back(new_w); due_qb.push_back(cyc + 2);
      end
      if (clr) clear_left = DEPTH;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("busy_a", {31'b0, busy_a}, {31'b0, clear_left > 0});
    chk("busy_b", {31'b0, busy_b}, {31'b0, clear_left > 0});
    exp_v = (due_qa.size() > 0) && (due_qa[0] == cyc);
    chk("vld_a", {31'b0, vld_a}, {31'b0, exp_v});
    if (exp_v) begin
      last_a = exp_qa.pop_front();
      void'(due_qa.pop_front());
    end
    chk("dout_a", dout_a, last_a);
    exp_v = (due_qb.size() > 0) && (due_qb[0] == cyc);
    chk("vld_b", {31'b0, vld_b}, {31'b0, exp_v});
    if (exp_v) begin
      last_b = exp_qb.pop_front();
      void'(due_qb.pop_front());
    end
    chk("dout_b", dout_b, last_b);
    if (vld_a) begin seen_a = 1'b1; val_a = dout_a; end
    if (vld_b) begin
      seen_b = 1'b1; val_b = dout_b;
      if (collect_b) sb_q.push_back(cyc);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    seen_a = 1'b0; seen_b = 1'b0;
    req = 1'b1; we = v.we; addr = v.addr; be = v.be; din = v.din;
    step();
    req = 1'b0;
    repeat (3) step();
    chk({nm, "_seen_a"}, {31'b0, seen_a}, 32'd1);
    chk({nm, "_seen_b"}, {31'b0, seen_b}, 32'd1);
    chk({nm, "_rf"}, val_a, v.exp_rf);
    chk({nm, "_wf"}, val_b, v.exp_wf);
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy_a && n < 40) begin
      step();
      n++;
    end
    chk(nm, n, DEPTH);
  endtask

  initial begin
    int start;
    vec_t rv;
    cyc = 0; clear_left = DEPTH; last_a = '0; last_b = '0;
    collect_b = 1'b0; seen_a = 1'b0; seen_b = 1'b0; val_a = '0; val_b = '0;
    rst = 1'b1; clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; din = '0;

    vecs[0]  = '{1'b1, 4'd3, 4'hF, 32'h11223344, CLR_V,        32'h11223344};
    vecs[1]  = '{1'b1, 4'd3, 4'h5, 32'hFFFFFFFF, 32'h11223344, 32'h11FF33FF};
    vecs[2]  = '{1'b0, 4'd3, 4'h0, 32'h0,        32'h11FF33FF, 32'h11FF33FF};
    vecs[3]  = '{1'b1, 4'd5, 4'hF, 32'h00000000, CLR_V,        32'h00000000};
    vecs[4]  = '{1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 4'd5, 4'hF, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 4'd7, 4'h0, 32'h12345678, CLR_V,        CLR_V};
    vecs[7]  = '{1'b0, 4'd7, 4'h0, 32'h0,        CLR_V,        CLR_V};
    vecs[8]  = '{1'b1, 4'd0, 4'h8, 32'hAABBCCDD, CLR_V,        32'hAAA5A5A5};
    vecs[9]  = '{1'b0, 4'd0, 4'h0, 32'h0,        32'hAAA5A5A5, 32'hAAA5A5A5};
    vecs[10] = '{1'b1, 4'd15, 4'h6, 32'h01020304, CLR_V,       32'hA50203A5};
    vecs[11] = '{1'b0, 4'd15, 4'h0, 32'h0,       32'hA50203A5, 32'hA50203A5};

    // reset and initial clear
    step(); step();
    rst = 1'b0;
    count_busy("reset_clear_len");
    for (int i = 0; i < DEPTH; i++) begin
      rv = '{1'b0, 4'(i), 4'h0, 32'h0, CLR_V, CLR_V};
      run_vec(rv, "clear_val");
    end

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // back-to-back reads, latency 2 on the registered instance
    sb_q.delete();
    collect_b = 1'b1;
    start = cyc;
    for (int i = 0; i < DEPTH; i++) begin
      req = 1'b1; we = 1'b0; addr = 4'(i);
      step();
    end
    req = 1'b0;
    repeat (4) step();
    collect_b = 1'b0;
    chk("b2b_count", sb_q.size(), DEPTH);
    if (sb_q.size() == DEPTH) begin
      chk("b2b_first", sb_q[0], start + 2);
      chk("b2b_span", sb_q[DEPTH-1] - sb_q[0], DEPTH - 1);
    end

    // clear arriving with a read in flight
    rv = '{1'b1, 4'd2, 4'hF, 32'h0BADF00D, CLR_V, 32'h0BADF00D};
    run_vec(rv, "pre_clr_wr");
    seen_a = 1'b0; seen_b = 1'b0;
    req = 1'b1; we = 1'b0; addr = 4'd2; clr = 1'b1;
    step();
    clr = 1'b0; we = 1'b1; be = 4'hF; din = 32'hFFFFFFFF;
    count_busy("clr_len");
    req = 1'b0;
    chk("clr_inflight_a", val_a, 32'h0BADF00D);
    chk("clr_inflight_b", val_b, 32'h0BADF00D);
    rv = '{1'b0, 4'd2, 4'h0, 32'h0, CLR_V, CLR_V};
    run_vec(rv, "post_clr_rd");

    // reset landing mid-sweep at address 9
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy("rst_midclr_len");

    // random traffic with occasional clear / reset
    for (int i = 0; i < 600; i++) begin
      req  = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1);
      addr = 4'($urandom_range(0, 15));
      be   = 4'($urandom_range(0, 15));
      din  = $urandom;
      clr  = ($urandom_range(0, 79) == 0);
      rst  = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0; req = 1'b0;
    repeat (DEPTH + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
